// File: rtl/parity_pkg.sv
// Shared definitions for the parity generator / checker path.
//  state_t  : deframer FSM state encoding
//  PAR_EVEN / PAR_ODD : values for the ODD_PARITY parameter
package parity_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

// File: rtl/parity_accum.sv
// Running-XOR parity cell, shared by the generator and checker sides.
//  clk  : rising-edge clock
//  clr  : synchronous clear to 0 (wins over en)
//  en   : fold d into the accumulator this cycle
//  d    : data bit
//  q    : accumulated parity (XOR of all enabled bits since last clear)
module parity_accum (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= 1'b0;
    end else if (en) begin
      q <= q ^ d;
    end
  end

endmodule

// File: rtl/parity_frame_checker.sv
// Serial frame deframer and parity checker.
// Frame: start 0, DATA_BITS data bits LSB-first, one parity bit, stop 1.
//  clk        : rising-edge clock
//  rst_n      : synchronous active-low reset
//  bit_in     : serial bit, sampled only when bit_valid=1
//  bit_valid  : qualifies bit_in; 0 stalls FSM, counter, accumulator and shifter
//  clr_err    : synchronous clear of err_count (wins over an increment)
//  data_out   : last received word, held until the next frame completes
//  data_valid : one-cycle pulse the cycle after the stop bit is sampled
//  parity_err : parity mismatch for the word on data_out
//  frame_err  : stop bit was 0 for the word on data_out
//  busy       : 1 while a frame is in progress (state != IDLE)
//  err_count  : saturating count of frames with parity_err|frame_err
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = PAR_EVEN,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  // A 1-bit frame still needs a 1-bit counter.
  localparam int              CNT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic            PAR_BIT  = (ODD_PARITY != PAR_EVEN);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 perr;
  logic                 acc;
  logic                 acc_clr;
  logic                 acc_en;
  logic                 stop_fire;
  logic                 frame_bad;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Accumulator restarts on reset and on every accepted start bit.
  assign acc_clr   = ~rst_n | (state == S_IDLE && bit_valid && ~bit_in);
  assign acc_en    = bit_valid && (state == S_DATA);
  assign stop_fire = bit_valid && (state == S_STOP);
  assign frame_bad = perr | ~bit_in;
  assign busy      = (state != S_IDLE);

  parity_accum u_accum (
    .clk (clk),
    .clr (acc_clr),
    .en  (acc_en),
    .d   (bit_in),
    .q   (acc)
  );

  // Data capture: shifter is plain data and carries no reset.
  always_ff @(posedge clk) begin
    if (acc_en) begin
      shift_reg[cnt] <= bit_in;
    end
  end

  // FSM, output registers and error counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      perr       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= '0;
    end else begin
      data_valid <= 1'b0;
      if (bit_valid) begin
        case (state)
          S_IDLE: begin
            if (!bit_in) begin
              state <= S_DATA;
              cnt   <= '0;
            end
          end
          S_DATA: begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= S_PARITY;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_PARITY: begin
            perr  <= (acc ^ bit_in) != PAR_BIT;
            state <= S_STOP;
          end
          S_STOP: begin
            data_out   <= shift_reg;
            parity_err <= perr;
            frame_err  <= ~bit_in;
            data_valid <= 1'b1;
            state      <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
      if (clr_err) begin
        err_count <= '0;
      end else if (stop_fire && frame_bad) begin
        err_count <= sat_inc(err_count);
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: three instances (even/8-bit count, odd/8-bit
// count, even/2-bit count) share one directed stimulus stream and are checked
// every cycle against a bit-list frame model, plus literal expectations.
module tb_parity_frame_checker;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst_n, bit_in, bit_valid, clr_err;
  logic [DB-1:0] d0, d1, d2;
  logic dv0, dv1, dv2, pe0, pe1, pe2, fe0, fe1, fe2, bz0, bz1, bz2;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  int n_cmp = 0;
  int n_fail = 0;
  int dv_pulses = 0;
  bit started = 0;

  always #5 clk = ~clk;

  parity_frame_checker #(.DATA_BITS(DB), .ODD_PARITY(0), .ERR_CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .clr_err(clr_err),
    .data_out(d0), .data_valid(dv0), .parity_err(pe0), .frame_err(fe0), .busy(bz0), .err_count(c0));
  parity_frame_checker #(.DATA_BITS(DB), .ODD_PARITY(1), .ERR_CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .clr_err(clr_err),
    .data_out(d1), .data_valid(dv1), .parity_err(pe1), .frame_err(fe1), .busy(bz1), .err_count(c1));
  parity_frame_checker #(.DATA_BITS(DB), .ODD_PARITY(0), .ERR_CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .clr_err(clr_err),
    .data_out(d2), .data_valid(dv2), .parity_err(pe2), .frame_err(fe2), .busy(bz2), .err_count(c2));

  // ---------------- model: collect accepted bits, evaluate whole frames ----
  int odd_cfg[3]  = '{0, 1, 0};
  int cnt_max[3]  = '{255, 255, 3};
  int exp_cnt[3];
  bit exp_pe[3];
  bit exp_fe, exp_dv, exp_busy;
  int exp_data;
  bit collecting;
  int nbits;
  bit fr[DB+2];

  always @(posedge clk) begin
    exp_dv = 1'b0;
    if (!rst_n) begin
      collecting = 1'b0;
      nbits = 0;
      exp_data = 0;
      exp_fe = 1'b0;
      for (int i = 0; i < 3; i++) begin
        exp_pe[i] = 1'b0;
        exp_cnt[i] = 0;
      end
    end else begin
      if (bit_valid) begin
        if (!collecting) begin
          if (!bit_in) begin
            collecting = 1'b1;
            nbits = 0;
          end
        end else begin
          fr[nbits] = bit_in;
          nbits++;
          if (nbits == DB + 2) begin
            int ones;
            exp_data = 0;
            for (int i = 0; i < DB; i++) exp_data += int'(fr[i]) << i;
            ones = $countones(exp_data) + int'(fr[DB]);
            exp_fe = !fr[DB+1];
            exp_dv = 1'b1;
            for (int i = 0; i < 3; i++) begin
              exp_pe[i] = (ones % 2) != odd_cfg[i];
              if ((exp_pe[i] || exp_fe) && exp_cnt[i] < cnt_max[i]) exp_cnt[i]++;
            end
            collecting = 1'b0;
          end
        end
      end
      if (clr_err) for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    end
    exp_busy = collecting;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("data_out0", d0, exp_data);   chk("data_out1", d1, exp_data);   chk("data_out2", d2, exp_data);
      chk("data_valid0", dv0, exp_dv);  chk("data_valid1", dv1, exp_dv);  chk("data_valid2", dv2, exp_dv);
      chk("parity_err0", pe0, exp_pe[0]); chk("parity_err1", pe1, exp_pe[1]); chk("parity_err2", pe2, exp_pe[2]);
      chk("frame_err0", fe0, exp_fe);   chk("frame_err1", fe1, exp_fe);   chk("frame_err2", fe2, exp_fe);
      chk("busy0", bz0, exp_busy);      chk("busy1", bz1, exp_busy);      chk("busy2", bz2, exp_busy);
      chk("err_count0", c0, exp_cnt[0]); chk("err_count1", c1, exp_cnt[1]); chk("err_count2", c2, exp_cnt[2]);
      if (dv0) dv_pulses++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_bit(input logic b, input bit jit);
    if (jit) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          bit_valid = 1'b0;
          bit_in = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
    end
    bit_valid = 1'b1;
    bit_in = b;
    @(negedge clk);
    bit_valid = 1'b0;
    bit_in = 1'b1;
  endtask

  task automatic send_frame(input logic [DB-1:0] data, input logic par, input logic stop,
                            input bit jit, input bit clr_at_stop);
    send_bit(1'b0, jit);
    for (int i = 0; i < DB; i++) send_bit(data[i], jit);
    send_bit(par, jit);
    if (clr_at_stop) clr_err = 1'b1;
    send_bit(stop, jit);
    clr_err = 1'b0;
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    bit_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int p;
    rst_n = 1'b0; bit_in = 1'b1; bit_valid = 1'b0; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    started = 1'b1;
    rst_n = 1'b1;

    // 1: reset mid-frame after 4 data bits, held 3 cycles
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    chk("lit_rst_pulses", dv_pulses, 0);
    chk("lit_rst_data", d0, 0);
    chk("lit_rst_busy", bz0, 0);
    chk("lit_rst_cnt", c0, 0);

    // 2: 0xA5 even parity correct
    send_frame(8'hA5, 1'b0, 1'b1, 0, 0);
    chk("lit_a5_data", d0, 8'hA5);
    chk("lit_a5_dv", dv0, 1);
    chk("lit_a5_perr", pe0, 0);
    chk("lit_a5_ferr", fe0, 0);
    chk("lit_a5_cnt", c0, 0);
    chk("lit_a5_odd_perr", pe1, 1);
    chk("lit_a5_odd_cnt", c1, 1);
    idle(2);
    chk("lit_a5_dv_drop", dv0, 0);

    // 3: 0x01 with parity 0
    send_frame(8'h01, 1'b0, 1'b1, 0, 0);
    chk("lit_01_perr", pe0, 1);
    chk("lit_01_cnt", c0, 1);
    chk("lit_01_odd_perr", pe1, 0);
    chk("lit_01_odd_cnt", c1, 1);
    idle(2);

    // 4: 0x3C, good parity, bad stop
    send_frame(8'h3C, 1'b0, 1'b0, 0, 0);
    chk("lit_3c_ferr", fe0, 1);
    chk("lit_3c_dv", dv0, 1);
    chk("lit_3c_data", d0, 8'h3C);
    chk("lit_3c_cnt", c0, 2);
    chk("lit_3c_cnt2", c2, 2);
    idle(2);

    // 5: stalls inside a frame, then two frames with no gap
    p = dv_pulses;
    send_frame(8'h5A, 1'b0, 1'b1, 1, 0);
    chk("lit_5a_data", d0, 8'h5A);
    chk("lit_5a_perr", pe0, 0);
    chk("lit_5a_cnt", c0, 2);
    idle(1);
    send_frame(8'h12, 1'b0, 1'b1, 0, 0);
    chk("lit_b2b_first", d0, 8'h12);
    send_frame(8'h7F, 1'b1, 1'b1, 0, 0);
    chk("lit_b2b_second", d0, 8'h7F);
    chk("lit_b2b_perr", pe0, 0);
    idle(2);
    chk("lit_b2b_pulses", dv_pulses - p, 3);

    // 6: saturation and clear
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    chk("lit_clr_cnt", c0, 0);
    for (int f = 0; f < 5; f++) send_frame(8'h01, 1'b0, 1'b1, 0, 0);
    chk("lit_sat_cnt8", c0, 5);
    chk("lit_sat_cnt2", c2, 3);
    idle(1);
    send_frame(8'h01, 1'b0, 1'b1, 0, 1);
    chk("lit_clrwin_cnt", c0, 0);
    chk("lit_clrwin_cnt2", c2, 0);
    chk("lit_clrwin_perr", pe0, 1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
